// File: rtl/arb_client_pkg.sv
// Shared types for the arbiter requester agent: FSM state encoding and default job length type.
package arb_client_pkg;

  localparam int LEN_W_DFLT = 4;

  typedef logic [LEN_W_DFLT-1:0] len_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } state_t;

endpackage

// File: rtl/arb_client_fifo.sv
// Job FIFO for arb_req_client: DEPTH entries of job length, wrap-around pointers plus occupancy count.
module arb_client_fifo #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [LEN_W-1:0]       din,
  input  logic                   pop,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [LEN_W-1:0]       head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [LEN_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // NOTE: storage has no reset; the count and pointers alone decide which entries are valid.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/arb_req_client.sv
// Requester-side agent for a 2-way req/gnt arbiter: queues bursts, drives req, counts beats,
// survives preemption, inserts a one-cycle gap between bursts and flags starvation.
module arb_req_client
  import arb_client_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int LEN_W    = LEN_W_DFLT,
  parameter int STARVE_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   job_valid,
  input  logic [LEN_W-1:0]       job_len,
  output logic                   job_ready,
  output logic                   req,
  input  logic                   gnt,
  output logic                   beat,
  output logic                   done,
  output logic                   starve,
  output logic [$clog2(DEPTH):0] pending
);

  localparam logic [STARVE_W-1:0] WAIT_MAX = '1;

  state_t              state;
  state_t              state_nxt;
  logic [LEN_W-1:0]    remaining;
  logic [LEN_W-1:0]    fifo_head;
  logic [STARVE_W-1:0] wait_cnt;
  logic [STARVE_W-1:0] wait_nxt;
  logic                fifo_full;
  logic                fifo_empty;
  logic                last_beat;
  logic                load_rem;

  assign job_ready = ~fifo_full;

  arb_client_fifo #(
    .DEPTH (DEPTH),
    .LEN_W (LEN_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (job_valid & ~fifo_full),
    .din   (job_len),
    .pop   (last_beat),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (pending),
    .head  (fifo_head)
  );

  // State register; req is a flop so the arbiter sees a clean, registered request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      req   <= 1'b0;
    end else begin
      state <= state_nxt;
      req   <= (state_nxt == ACTIVE);
    end
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty) state_nxt = ACTIVE;
      ACTIVE:  if (last_beat)   state_nxt = GAP;
      GAP:     state_nxt = fifo_empty ? IDLE : ACTIVE;
      default: state_nxt = IDLE;
    endcase
  end

  // A grant with req low is a protocol error and never forms a beat.
  always_comb begin
    beat      = req & gnt;
    last_beat = beat && (remaining == '0);
    load_rem  = (state_nxt == ACTIVE) && (state != ACTIVE);
  end

  // Wait counter only runs while requesting without a grant; everything else clears it.
  always_comb begin
    wait_nxt = '0;
    if (state == ACTIVE && !gnt)
      wait_nxt = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining <= '0;
      wait_cnt  <= '0;
      done      <= 1'b0;
      starve    <= 1'b0;
    end else begin
      if (load_rem)
        remaining <= fifo_head;
      else if (beat && remaining != '0)
        remaining <= remaining - 1'b1;
      wait_cnt <= wait_nxt;
      done     <= last_beat;
      starve   <= (wait_nxt == WAIT_MAX);
    end
  end

endmodule
